// File: rtl/rotary_bcd_adjust.sv
// Rotary encoder value adjuster: synchronised/debounced EC11 decode, bounded value
// with wrap/saturate and acceleration, sequential binary-to-BCD with blank mask.
module rotary_bcd_adjust #(
  parameter int DIGITS     = 2,
  parameter int MIN_VAL    = 0,
  parameter int MAX_VAL    = 99,
  parameter int INIT_VAL   = 0,
  parameter int WRAP       = 0,
  parameter int DEB_CYCLES = 12000,
  parameter int FAST_WIN   = 1200000,
  parameter int FAST_STEP  = 10,
  localparam int W         = $clog2(MAX_VAL + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_a,
  input  logic                key_b,
  output logic [W-1:0]        value,
  output logic [4*DIGITS-1:0] bcd,
  output logic                bcd_upd,
  output logic                up_pulse,
  output logic                dn_pulse,
  output logic                at_min,
  output logic                at_max,
  output logic [DIGITS-1:0]   blank
);

  localparam int DW = $clog2(DEB_CYCLES);
  localparam int IW = $clog2(FAST_WIN + 1);
  localparam int SW = W + 1;
  localparam int CW = $clog2(W + 1);
  localparam int BW = 4 * DIGITS;

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_SAT  = IW'(FAST_WIN);
  localparam logic [IW-1:0] IDLE_FAST = IW'(FAST_WIN - 1);
  localparam logic [W-1:0]  MIN_V     = W'(MIN_VAL);
  localparam logic [W-1:0]  MAX_V     = W'(MAX_VAL);
  localparam logic [W-1:0]  INIT_V    = W'(INIT_VAL);
  localparam logic [SW-1:0] MIN_X     = SW'(MIN_VAL);
  localparam logic [SW-1:0] MAX_X     = SW'(MAX_VAL);
  localparam logic [SW-1:0] FAST_X    = SW'(FAST_STEP);
  localparam logic [CW-1:0] W_CNT     = CW'(W);

  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DN} dir_t;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} conv_state_t;

  logic [1:0] pin_raw;
  logic [1:0] deb_lvl;

  assign pin_raw = {key_b, key_a};

  genvar gi;

  // Channel 0 is A, channel 1 is B; pins idle high so everything resets to 1.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_deb
      logic          sync1_reg;
      logic          sync2_reg;
      logic          deb_reg;
      logic [DW-1:0] cnt_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync1_reg <= 1'b1;
          sync2_reg <= 1'b1;
          deb_reg   <= 1'b1;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= pin_raw[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg == deb_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DEB_LAST) begin
            deb_reg <= sync2_reg;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign deb_lvl[gi] = deb_reg;
    end
  endgenerate

  logic deb_a_d_reg;
  logic step_req_reg;
  logic step_cw_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_a_d_reg  <= 1'b1;
      step_req_reg <= 1'b0;
      step_cw_reg  <= 1'b0;
    end else begin
      deb_a_d_reg  <= deb_lvl[0];
      step_req_reg <= deb_a_d_reg & ~deb_lvl[0];
      step_cw_reg  <= deb_lvl[1];
    end
  end

  dir_t          last_dir_reg;
  logic [IW-1:0] idle_cnt_reg;
  logic [W-1:0]  value_reg;
  logic [W-1:0]  value_next;
  logic [SW-1:0] step_amt;
  logic [SW-1:0] value_ext;
  logic [SW-1:0] sum_up;
  logic          fast;
  logic          value_chg;
  logic          up_pulse_reg;
  logic          dn_pulse_reg;

  // idle_cnt is cleared on a step, so elapsed cycles at the next step is idle_cnt+1.
  always_comb begin
    fast       = (idle_cnt_reg < IDLE_FAST) &&
                 (step_cw_reg ? (last_dir_reg == DIR_UP) : (last_dir_reg == DIR_DN));
    step_amt   = fast ? FAST_X : SW'(1);
    value_ext  = {1'b0, value_reg};
    sum_up     = value_ext + step_amt;
    value_next = value_reg;
    if (step_req_reg) begin
      if (step_cw_reg) begin
        if (sum_up > MAX_X) begin
          value_next = (WRAP != 0) ? MIN_V : MAX_V;
        end else begin
          value_next = sum_up[W-1:0];
        end
      end else begin
        if (value_ext < MIN_X + step_amt) begin
          value_next = (WRAP != 0) ? MAX_V : MIN_V;
        end else begin
          value_next = W'(value_ext - step_amt);
        end
      end
    end
  end

  assign value_chg = step_req_reg && (value_next != value_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_reg    <= INIT_V;
      idle_cnt_reg <= IDLE_SAT;
      last_dir_reg <= DIR_NONE;
      up_pulse_reg <= 1'b0;
      dn_pulse_reg <= 1'b0;
    end else begin
      value_reg    <= value_next;
      up_pulse_reg <= step_req_reg & step_cw_reg;
      dn_pulse_reg <= step_req_reg & ~step_cw_reg;
      if (step_req_reg) begin
        idle_cnt_reg <= '0;
        last_dir_reg <= step_cw_reg ? DIR_UP : DIR_DN;
      end else if (idle_cnt_reg != IDLE_SAT) begin
        idle_cnt_reg <= idle_cnt_reg + 1'b1;
      end
    end
  end

  conv_state_t   state_reg;
  logic          pending_reg;
  logic [W-1:0]  bin_reg;
  logic [BW-1:0] scratch_reg;
  logic [BW-1:0] scratch_adj;
  logic [BW-1:0] bcd_reg;
  logic [CW-1:0] bit_cnt_reg;
  logic          bcd_upd_reg;

  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_add3
      assign scratch_adj[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5) ?
                                      scratch_reg[4*gi +: 4] + 4'd3 :
                                      scratch_reg[4*gi +: 4];
    end
  endgenerate

  // A value change during SHIFT re-arms pending; the set below overrides the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      pending_reg <= 1'b1;
      bin_reg     <= '0;
      scratch_reg <= '0;
      bit_cnt_reg <= '0;
      bcd_reg     <= '0;
      bcd_upd_reg <= 1'b0;
    end else begin
      bcd_upd_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (pending_reg) begin
            state_reg   <= ST_SHIFT;
            bin_reg     <= value_reg;
            scratch_reg <= '0;
            bit_cnt_reg <= '0;
            pending_reg <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (bit_cnt_reg == W_CNT) begin
            bcd_reg     <= scratch_reg;
            bcd_upd_reg <= 1'b1;
            state_reg   <= ST_DONE;
          end else begin
            scratch_reg <= {scratch_adj[BW-2:0], bin_reg[W-1]};
            bin_reg     <= bin_reg << 1;
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
      if (value_chg) begin
        pending_reg <= 1'b1;
      end
    end
  end

  assign blank[0] = 1'b0;
  generate
    for (gi = 1; gi < DIGITS; gi++) begin : g_blank
      assign blank[gi] = (bcd_reg[BW-1:4*gi] == '0);
    end
  endgenerate

  assign value    = value_reg;
  assign bcd      = bcd_reg;
  assign bcd_upd  = bcd_upd_reg;
  assign up_pulse = up_pulse_reg;
  assign dn_pulse = dn_pulse_reg;
  assign at_min   = (value_reg == MIN_V);
  assign at_max   = (value_reg == MAX_V);

endmodule

// File: tb/tb_rotary_bcd_adjust.sv
// Scoreboard bench for rotary_bcd_adjust: two instances (saturate from 42, wrap from 0)
// driven with directed detents; a monitor checks every step and conversion strobe.
module tb_rotary_bcd_adjust;

  localparam int W        = 7;
  localparam int LAT_STEP = 7;   // edge0 + DEB_CYCLES + 3

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a0 = 1'b1, b0 = 1'b1, a1 = 1'b1, b1 = 1'b1;
  logic [W-1:0] val0, val1;
  logic [7:0]   bcd0, bcd1;
  logic         upd0, upd1, up0, up1, dn0, dn1, amin0, amin1, amax0, amax1;
  logic [1:0]   blank0, blank1;

  typedef struct { bit cw; int val; int cyc; } step_t;
  typedef struct { int val; int cyc; } conv_t;

  step_t sq0[$], sq1[$];
  conv_t cq0[$], cq1[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  rotary_bcd_adjust #(.DIGITS(2), .MIN_VAL(0), .MAX_VAL(99), .INIT_VAL(42), .WRAP(0),
                      .DEB_CYCLES(4), .FAST_WIN(50), .FAST_STEP(10)) dut0 (
    .clk(clk), .rst(rst), .key_a(a0), .key_b(b0), .value(val0), .bcd(bcd0),
    .bcd_upd(upd0), .up_pulse(up0), .dn_pulse(dn0), .at_min(amin0), .at_max(amax0),
    .blank(blank0));

  rotary_bcd_adjust #(.DIGITS(2), .MIN_VAL(0), .MAX_VAL(99), .INIT_VAL(0), .WRAP(1),
                      .DEB_CYCLES(4), .FAST_WIN(50), .FAST_STEP(10)) dut1 (
    .clk(clk), .rst(rst), .key_a(a1), .key_b(b1), .value(val1), .bcd(bcd1),
    .bcd_upd(upd1), .up_pulse(up1), .dn_pulse(dn1), .at_min(amin1), .at_max(amax1),
    .blank(blank1));

  function automatic logic [31:0] to_bcd(input int v);
    return 32'(((v / 10) % 10) * 16 + (v % 10));
  endfunction

  function automatic logic [31:0] to_blank(input int v);
    return (v < 10) ? 32'd2 : 32'd0;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, got, got, exp, exp, cyc);
    end
  endtask

  task automatic push_step(input int inst, input bit cw, input int val, input int c);
    step_t s;
    s.cw = cw; s.val = val; s.cyc = c;
    if (inst == 0) sq0.push_back(s);
    else           sq1.push_back(s);
  endtask

  task automatic push_conv(input int inst, input int val, input int c);
    conv_t e;
    e.val = val; e.cyc = c;
    if (inst == 0) cq0.push_back(e);
    else           cq1.push_back(e);
  endtask

  task automatic set_a(input int inst, input logic v);
    if (inst == 0) a0 = v; else a1 = v;
  endtask

  task automatic set_b(input int inst, input logic v);
    if (inst == 0) b0 = v; else b1 = v;
  endtask

  // One detent: A low for lo cycles then high for hi cycles; conv_off=0 means no value change.
  task automatic detent(input int inst, input bit cw, input int exp_val,
                        input int lo, input int hi, input int conv_off);
    int e0;
    if (!cw) begin
      set_b(inst, 1'b0);
      repeat (8) @(negedge clk);
    end
    set_a(inst, 1'b0);
    e0 = cyc + 1;
    push_step(inst, cw, exp_val, e0 + LAT_STEP);
    if (conv_off > 0) push_conv(inst, exp_val, e0 + LAT_STEP + conv_off);
    repeat (lo) @(negedge clk);
    set_a(inst, 1'b1);
    set_b(inst, 1'b1);
    repeat (hi) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      step_t s;
      conv_t c;
      if (up0 || dn0) begin
        if (sq0.size() == 0) begin
          tests++; fails++;
          $display("FAIL d0_step_extra: got step value %0d expected no step at cycle %0d", val0, cyc);
        end else begin
          s = sq0.pop_front();
          $display("[TB] d0 step cyc=%0d up=%0d dn=%0d value=%0d", cyc, up0, dn0, val0);
          chk("d0_dir", 32'({up0, dn0}), s.cw ? 32'd2 : 32'd1);
          chk("d0_value", 32'(val0), 32'(s.val));
          chk("d0_step_cyc", 32'(cyc), 32'(s.cyc));
          chk("d0_at_max", 32'(amax0), 32'(s.val == 99));
          chk("d0_at_min", 32'(amin0), 32'(s.val == 0));
        end
      end
      if (upd0) begin
        if (cq0.size() == 0) begin
          tests++; fails++;
          $display("FAIL d0_conv_extra: got bcd 0x%0h expected no strobe at cycle %0d", bcd0, cyc);
        end else begin
          c = cq0.pop_front();
          $display("[TB] d0 conv cyc=%0d bcd=%02h blank=%b", cyc, bcd0, blank0);
          chk("d0_bcd", 32'(bcd0), to_bcd(c.val));
          chk("d0_blank", 32'(blank0), to_blank(c.val));
          chk("d0_conv_cyc", 32'(cyc), 32'(c.cyc));
        end
      end
      if (up1 || dn1) begin
        if (sq1.size() == 0) begin
          tests++; fails++;
          $display("FAIL d1_step_extra: got step value %0d expected no step at cycle %0d", val1, cyc);
        end else begin
          s = sq1.pop_front();
          $display("[TB] d1 step cyc=%0d up=%0d dn=%0d value=%0d", cyc, up1, dn1, val1);
          chk("d1_dir", 32'({up1, dn1}), s.cw ? 32'd2 : 32'd1);
          chk("d1_value", 32'(val1), 32'(s.val));
          chk("d1_step_cyc", 32'(cyc), 32'(s.cyc));
          chk("d1_at_max", 32'(amax1), 32'(s.val == 99));
          chk("d1_at_min", 32'(amin1), 32'(s.val == 0));
        end
      end
      if (upd1) begin
        if (cq1.size() == 0) begin
          tests++; fails++;
          $display("FAIL d1_conv_extra: got bcd 0x%0h expected no strobe at cycle %0d", bcd1, cyc);
        end else begin
          c = cq1.pop_front();
          $display("[TB] d1 conv cyc=%0d bcd=%02h blank=%b", cyc, bcd1, blank1);
          chk("d1_bcd", 32'(bcd1), to_bcd(c.val));
          chk("d1_blank", 32'(blank1), to_blank(c.val));
          chk("d1_conv_cyc", 32'(cyc), 32'(c.cyc));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_value0", 32'(val0), 32'd42);
    chk("rst_bcd0", 32'(bcd0), 32'd0);
    chk("rst_strobes0", 32'({upd0, up0, dn0}), 32'd0);
    chk("rst_value1", 32'(val1), 32'd0);
    chk("rst_bcd1", 32'(bcd1), 32'd0);
    push_conv(0, 42, W + 2);
    push_conv(1, 0, W + 2);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Saturating instance
    detent(0, 1'b1, 43, 20, 80, 9);
    for (int k = 0; k < 6; k++) begin
      a0 = (k % 2 == 1);
      repeat (2) @(negedge clk);
    end
    begin
      int e0;
      a0 = 1'b0;
      e0 = cyc + 1;
      push_step(0, 1'b1, 44, e0 + LAT_STEP);
      push_conv(0, 44, e0 + LAT_STEP + 9);
      repeat (20) @(negedge clk);
      a0 = 1'b1;
      repeat (80) @(negedge clk);
    end
    a0 = 1'b0;
    repeat (3) @(negedge clk);
    a0 = 1'b1;
    repeat (80) @(negedge clk);
    chk("d0_glitch_value", 32'(val0), 32'd44);

    detent(0, 1'b1, 45, 10, 20, 9);
    detent(0, 1'b1, 55, 10, 20, 9);
    detent(0, 1'b1, 65, 10, 20, 9);
    detent(0, 1'b1, 75, 10, 20, 9);
    detent(0, 1'b1, 85, 10, 20, 9);
    detent(0, 1'b1, 95, 10, 80, 9);
    detent(0, 1'b1, 96, 20, 80, 9);
    detent(0, 1'b1, 97, 20, 80, 9);
    detent(0, 1'b1, 98, 20, 80, 9);
    detent(0, 1'b1, 99, 10, 20, 9);
    detent(0, 1'b1, 99, 10, 20, 0);
    detent(0, 1'b1, 99, 10, 80, 0);
    chk("d0_at_max_hold", 32'(amax0), 32'd1);

    // Wrapping instance
    detent(1, 1'b0, 99, 20, 80, 9);
    detent(1, 1'b1, 0, 20, 80, 9);
    for (int v = 1; v <= 5; v++) detent(1, 1'b1, v, 20, 80, 9);
    chk("d1_bcd_5", 32'(bcd1), 32'h05);
    chk("d1_blank_5", 32'(blank1), 32'd2);
    detent(1, 1'b1, 6, 10, 20, 9);
    detent(1, 1'b1, 16, 10, 100, 9);
    detent(1, 1'b1, 17, 10, 20, 9);
    detent(1, 1'b0, 16, 10, 20, 9);
    detent(1, 1'b1, 17, 4, 4, 9);
    detent(1, 1'b1, 27, 4, 80, 11);
    chk("d1_final_bcd", 32'(bcd1), 32'h27);

    // Reset in the middle of a debounce
    a0 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_value0", 32'(val0), 32'd42);
    chk("midrst_bcd0", 32'(bcd0), 32'd0);
    chk("midrst_strobes0", 32'({upd0, up0, dn0}), 32'd0);
    chk("midrst_value1", 32'(val1), 32'd0);
    a0 = 1'b1;
    repeat (3) @(negedge clk);
    push_conv(0, 42, W + 2);
    push_conv(1, 0, W + 2);
    rst = 1'b0;
    repeat (30) @(negedge clk);

    chk("sq0_empty", 32'(sq0.size()), 32'd0);
    chk("cq0_empty", 32'(cq0.size()), 32'd0);
    chk("sq1_empty", 32'(sq1.size()), 32'd0);
    chk("cq1_empty", 32'(cq1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
